fft_sequencer: RTL

Control sequencer for the in-place, ping-pong radix-2 FFT datapath: one butterfly unit, two dual-port RAMs (ram0, ram1) and a twiddle ROM. Handles three phases:
- Load: accepts samples into ram0 in bit-reversed order.
- Compute: walks M levels of N/2 butterflies, one per clock, alternating RAM direction each level.
- Done: serves naturally ordered results from the RAM holding the final level.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_agu.sv | 28 ++
 rtl/fft_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 FFT sequencer.
// Helpers work on 32-bit values with the active width passed in as m.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

   function automatic logic [31:0] bitrev(input logic [31:0] x, input int m);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < m; k++) r[k] = x[m-1-k];
      return r;
   endfunction

   // Left rotate within the low m bits; s must be below m.
   function automatic logic [31:0] rotl(input logic [31:0] x, input int s, input int m);
      logic [31:0] mask;
      logic [31:0] xm;
      mask = (32'd1 << m) - 32'd1;
      xm   = x & mask;
      return ((xm << s) | (xm >> (m - s))) & mask;
   endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: (level, butterfly) -> operand pair and twiddle.
// Operand pair is the adjacent pair (2j, 2j+1) rotated left by the level.
module fft_agu
   import fft_pkg::*;
#(
   parameter int M  = 5,
   parameter int IW = 3
) (
   input  logic [IW-1:0] lvl_i,
   input  logic [M-2:0]  bfly_i,
   output logic [M-1:0]  adr_a_o,
   output logic [M-1:0]  adr_b_o,
   output logic [M-2:0]  twiddle_o
);

   int          lvl_w;
   logic [31:0] even_w;

   assign lvl_w  = int'(lvl_i);
   assign even_w = 32'({bfly_i, 1'b0});

   assign adr_a_o = M'(rotl(even_w, lvl_w, M));
   assign adr_b_o = M'(rotl(even_w | 32'd1, lvl_w, M));

   // Twiddle stride halves each level: keep only the top (i) bits of j.
   assign twiddle_o = bfly_i & (M-1)'(~((32'd1 << (M - 1 - lvl_w)) - 32'd1));

endmodule

// File: rtl/fft_sequencer.sv
// Load / compute / readback controller for a ping-pong in-place radix-2 FFT.
// Each compute level reads one RAM and writes the other; reads are asynchronous.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int M = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         load,
   input  logic [M-1:0] rd_adr,
   output logic         done,
   output logic         rd_sel,
   output logic         we0,
   output logic         we1,
   output logic [M-1:0] adr0_a,
   output logic [M-1:0] adr0_b,
   output logic [M-1:0] adr1_a,
   output logic [M-1:0] adr1_b,
   output logic [M-2:0] twiddle_adr
);

   localparam int          IW      = (M > 1) ? $clog2(M) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(M - 1);
   localparam logic [M-2:0]  J_LAST = '1;
   localparam logic          RES_SEL = (M % 2 == 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic [M-2:0]    j_q, j_d;
   logic            done_q, done_d;

   logic [M-1:0]    rev_adr;
   logic [M-1:0]    agu_a, agu_b;
   logic [M-2:0]    agu_tw;

   assign rev_adr = M'(bitrev(32'(rd_adr), M));

   fft_agu #(.M(M), .IW(IW)) u_agu (
      .lvl_i     (i_q),
      .bfly_i    (j_q),
      .adr_a_o   (agu_a),
      .adr_b_o   (agu_b),
      .twiddle_o (agu_tw)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            // Load wins over start so a late sample is never lost.
            if (start && !load) begin
               state_d = COMPUTE;
               i_d     = '0;
               j_d     = '0;
            end
         end
         COMPUTE: begin
            j_d = j_q + 1'b1;
            if (j_q == J_LAST) begin
               if (i_q == I_LAST) begin
                  state_d = DONE;
                  i_d     = '0;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         DONE:    done_d  = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done        = done_q;
      rd_sel      = 1'b0;
      we0         = 1'b0;
      we1         = 1'b0;
      adr0_a      = '0;
      adr0_b      = '0;
      adr1_a      = '0;
      adr1_b      = '0;
      twiddle_adr = '0;
      case (state_q)
         IDLE: begin
            adr0_a = rev_adr;
            adr0_b = rev_adr;
            we0    = load;
         end
         COMPUTE: begin
            adr0_a      = agu_a;
            adr0_b      = agu_b;
            adr1_a      = agu_a;
            adr1_b      = agu_b;
            twiddle_adr = agu_tw;
            // Odd levels read ram1 and write back into ram0.
            if (i_q[0]) begin
               rd_sel = 1'b1;
               we0    = 1'b1;
            end else begin
               we1    = 1'b1;
            end
         end
         DONE: begin
            rd_sel = RES_SEL;
            if (RES_SEL) adr1_a = rd_adr;
            else         adr0_a = rd_adr;
         end
         default: ;
      endcase
   end

endmodule
